truth_table_sequencer: RTL and testbench
========================================

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 Parameter: SETTLE, default 1, meaning cycles each input vector is held before s1/s2 are sampled (legal 1..15).
REQ-002 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  one clock; reset is synchronous and active-low.
REQ-004 Port: start  input  1  run request, sampled only in IDLE.
REQ-005 Port: abort  input  1  cancels a run in progress.
REQ-006 Port: expected  input  16  golden table, expected[2i+1]=s1 and expected[2i]=s2 for vector i.
REQ-007 Port: s1  input  1  first output of the evaluated boolean block.
REQ-008 Port: s2  input  1  second output of the evaluated boolean block.
REQ-009 Port: x, y, z  output  1 each  stimulus to the evaluated block.
REQ-010 Port: busy  output  1  high in DRIVE and SAMPLE.
REQ-011 Port: done  output  1  one-cycle pulse at end of a complete run.
REQ-012 Port: result  output  16  captured table, same packing as expected.
REQ-013 Port: mismatch  output  8  bit i set when captured pair i differs from expected pair i.
REQ-014 Port: pass  output  1  high from DONE until next start/abort/reset when mismatch == 0.

Function
REQ-015 The block SHALL implement states IDLE, DRIVE, SAMPLE, DONE with a 3-bit row index idx and a 4-bit settle counter cnt.
REQ-016 IDLE: start=1 SHALL latch expected, clear result, mismatch, pass, set idx=0, cnt=0, go to DRIVE; otherwise stay.
REQ-017 DRIVE: {x,y,z} SHALL equal idx (x=idx[2], z=idx[0]); cnt increments each cycle; when cnt==SETTLE-1 go to SAMPLE.
REQ-018 SAMPLE: {x,y,z} SHALL still equal idx; {s1,s2} SHALL be written into result pair idx; mismatch[idx] SHALL be set if the pair differs from the latched expected pair (X/Z on s1/s2 counts as a difference).
REQ-019 SAMPLE with idx<7 SHALL increment idx, clear cnt, go to DRIVE; with idx==7 SHALL go to DONE.
REQ-020 DONE: done=1 and pass=(mismatch==0) for exactly one cycle, then IDLE; pass holds afterwards, done returns to 0.
REQ-021 Latency: start seen in IDLE at cycle t SHALL give done at cycle t+1+8*(SETTLE+1) (t+17 for SETTLE=1).
REQ-022 start while busy or in DONE SHALL be ignored; no queueing.
REQ-023 abort=1 in DRIVE or SAMPLE SHALL return to IDLE next cycle, no done pulse, pass=0, result/mismatch keep partial contents; abort in IDLE/DONE SHALL have no effect.
REQ-024 abort and a SAMPLE in the same cycle: abort wins, that sample is not written.
REQ-025 In IDLE, x, y, z SHALL be 0; expected changes after start latch SHALL not affect the run.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force IDLE, idx=0, cnt=0, x=y=z=0, busy=0, done=0, result=0, mismatch=0, pass=0, regardless of state, including mid-run.
REQ-027 rst_n=0 SHALL override start and abort in the same cycle.

Verification
REQ-028 Hold rst_n=0 two cycles -> all outputs 0, state IDLE.
REQ-029 Connect fxyz-equivalent model (s1 always 0, s2 always 1), SETTLE=1, expected=16'h5555, pulse start at t -> xyz steps 000..111 two cycles each, done at t+17, result=16'h5555, mismatch=8'h00, pass=1.
REQ-030 Same model, expected=16'h5557 -> mismatch=8'h01, pass=0, done still at t+17.
REQ-031 Abort asserted while idx=3 in SAMPLE -> IDLE next cycle, no done, pass=0, result pairs 0..2 = 2'b01, pair 3 unwritten (00).
REQ-032 Second start pulse at t+5 and at DONE cycle -> ignored, single done at t+17; start at t+18 begins new run.
REQ-033 SETTLE=3 -> each vector held 4 cycles (3 DRIVE + 1 SAMPLE), done at t+33; rst_n=0 at t+10 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: steps a 3-input boolean block through all eight
// input vectors, holds each vector for SETTLE cycles, samples the two
// outputs, and compares the captured table against a golden table that is
// latched when the run starts.
module truth_table_sequencer #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected,
  input  logic        s1,
  input  logic        s2,
  output logic        x,
  output logic        y,
  output logic        z,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [7:0]  mismatch,
  output logic        pass
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Last settle count before sampling; SETTLE is limited to 1..15.
  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] exp_q, exp_d;
  logic [15:0] result_q, result_d;
  logic [7:0]  mismatch_q, mismatch_d;
  logic        pass_q, pass_d;

  logic [1:0]  pair_obs;
  logic [1:0]  pair_exp;
  logic        pair_diff;

  // Observed and golden pair for the current row; case inequality so that
  // an X or Z on s1/s2 is reported as a difference in simulation.
  always_comb begin
    pair_obs  = {s1, s2};
    pair_exp  = exp_q[{idx_q, 1'b0} +: 2];
    pair_diff = (pair_obs !== pair_exp);
  end

  // Next-state and next-value logic for the sequencer.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    result_d   = result_q;
    mismatch_d = mismatch_q;
    pass_d     = pass_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          exp_d      = expected;
          result_d   = '0;
          mismatch_d = '0;
          pass_d     = 1'b0;
          idx_d      = '0;
          cnt_d      = '0;
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        if (abort) begin
          pass_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == CNT_LAST) begin
            state_d = SAMPLE;
          end
        end
      end
      SAMPLE: begin
        // Abort takes priority: the pending sample is discarded.
        if (abort) begin
          pass_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          result_d[{idx_q, 1'b0} +: 2] = pair_obs;
          mismatch_d[idx_q]            = pair_diff;
          if (idx_q == 3'd7) begin
            pass_d  = (mismatch_d == 8'h00);
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            cnt_d   = '0;
            state_d = DRIVE;
          end
        end
      end
      DONE: begin
        idx_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      exp_q      <= '0;
      result_q   <= '0;
      mismatch_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      result_q   <= result_d;
      mismatch_q <= mismatch_d;
      pass_q     <= pass_d;
    end
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    busy     = (state_q == DRIVE) || (state_q == SAMPLE);
    done     = (state_q == DONE);
    x        = busy & idx_q[2];
    y        = busy & idx_q[1];
    z        = busy & idx_q[0];
    result   = result_q;
    mismatch = mismatch_q;
    pass     = pass_q;
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer: one instance with SETTLE=1 and
// one with SETTLE=3, both driven by a constant model (s1=0, s2=1).
module tb_truth_table_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start1, start3;
  logic        abort;
  logic [15:0] expected;
  logic        s1, s2;

  logic        x1, y1, z1, busy1, done1, pass1;
  logic [15:0] result1;
  logic [7:0]  mismatch1;
  logic        x3, y3, z3, busy3, done3, pass3;
  logic [15:0] result3;
  logic [7:0]  mismatch3;

  int n_assert = 0;
  int n_fail   = 0;

  truth_table_sequencer #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
    .expected(expected), .s1(s1), .s2(s2),
    .x(x1), .y(y1), .z(z1), .busy(busy1), .done(done1),
    .result(result1), .mismatch(mismatch1), .pass(pass1)
  );

  truth_table_sequencer #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort),
    .expected(expected), .s1(s1), .s2(s2),
    .x(x3), .y(y3), .z(z3), .busy(busy3), .done(done3),
    .result(result3), .mismatch(mismatch3), .pass(pass3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check every output of dut1 against a full expected set.
  task automatic chk1(input string tag, input logic [2:0] xyz, input logic b,
                      input logic d, input logic [15:0] r, input logic [7:0] m,
                      input logic p);
    chk({tag, "_xyz"},      32'({x1, y1, z1}), 32'(xyz));
    chk({tag, "_busy"},     32'(busy1),        32'(b));
    chk({tag, "_done"},     32'(done1),        32'(d));
    chk({tag, "_result"},   32'(result1),      32'(r));
    chk({tag, "_mismatch"}, 32'(mismatch1),    32'(m));
    chk({tag, "_pass"},     32'(pass1),        32'(p));
  endtask

  task automatic chk3(input string tag, input logic [2:0] xyz, input logic b,
                      input logic d, input logic [15:0] r, input logic [7:0] m,
                      input logic p);
    chk({tag, "_xyz"},      32'({x3, y3, z3}), 32'(xyz));
    chk({tag, "_busy"},     32'(busy3),        32'(b));
    chk({tag, "_done"},     32'(done3),        32'(d));
    chk({tag, "_result"},   32'(result3),      32'(r));
    chk({tag, "_mismatch"}, 32'(mismatch3),    32'(m));
    chk({tag, "_pass"},     32'(pass3),        32'(p));
  endtask

  initial begin
    int n;
    int ndone;
    logic bad;

    rst_n    = 1'b0;
    start1   = 1'b0;
    start3   = 1'b0;
    abort    = 1'b0;
    expected = 16'h0000;
    s1       = 1'b0;
    s2       = 1'b1;

    // Reset held two cycles: everything idle and zero.
    tick();
    tick();
    chk1("rst1", 3'd0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    chk3("rst3", 3'd0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    rst_n = 1'b1;
    tick();
    chk1("idle1", 3'd0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);

    // Full matching run; expected is scrambled after the latch.
    expected = 16'h5555;
    start1   = 1'b1;
    bad      = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      start1 = 1'b0;
      if (k == 4) expected = 16'h0000;
      if ({x1, y1, z1} !== 3'((k - 1) / 2) || busy1 !== 1'b1 || done1 !== 1'b0) bad = 1'b1;
    end
    chk("run1_step_xyz_busy", 32'(bad), 32'd0);
    tick();
    chk1("run1_done", 3'd0, 1'b0, 1'b1, 16'h5555, 8'h00, 1'b1);
    tick();
    chk1("run1_after", 3'd0, 1'b0, 1'b0, 16'h5555, 8'h00, 1'b1);

    // Pair 0 expected as 11 while the model gives 01.
    expected = 16'h5557;
    start1   = 1'b1;
    n        = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      start1 = 1'b0;
      if (done1 === 1'b1) begin
        n = k;
        break;
      end
    end
    chk("run2_latency", 32'(n), 32'd17);
    chk1("run2_done", 3'd0, 1'b0, 1'b1, 16'h5555, 8'h01, 1'b0);
    tick();

    // Abort during SAMPLE of row 3: rows 0..2 kept, row 3 unwritten.
    expected = 16'h5555;
    start1   = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      start1 = 1'b0;
    end
    chk("abort_row", 32'({x1, y1, z1}), 32'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk1("abort_idle", 3'd0, 1'b0, 1'b0, 16'h0015, 8'h00, 1'b0);
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done1 === 1'b1) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    // Abort while idle has no effect.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk1("abort_in_idle", 3'd0, 1'b0, 1'b0, 16'h0015, 8'h00, 1'b0);

    // Start pulses while busy and in DONE are ignored.
    expected = 16'h5555;
    start1   = 1'b1;
    ndone    = 0;
    n        = 0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      start1 = (k == 5) || (k == 17) || (k == 18);
      if (done1 === 1'b1) begin
        ndone++;
        n = k;
      end
    end
    chk("ignore_done_count", 32'(ndone), 32'd1);
    chk("ignore_done_cycle", 32'(n), 32'd17);
    chk("ignore_busy_t18", 32'(busy1), 32'd0);
    tick();
    start1 = 1'b0;
    chk("restart_busy", 32'(busy1), 32'd1);
    chk("restart_pass_clr", 32'(pass1), 32'd0);
    n = 0;
    for (int k = 2; k <= 40; k++) begin
      tick();
      if (done1 === 1'b1) begin
        n = k;
        break;
      end
    end
    chk("restart_latency", 32'(n), 32'd17);
    tick();

    // Reset overrides start in the same cycle.
    rst_n  = 1'b0;
    start1 = 1'b1;
    tick();
    rst_n  = 1'b1;
    start1 = 1'b0;
    chk1("rst_over_start", 3'd0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    tick();
    chk("rst_over_start_idle", 32'(busy1), 32'd0);

    // SETTLE=3: each vector held four cycles, done 33 cycles after start.
    expected = 16'h5555;
    start3   = 1'b1;
    bad      = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      start3 = 1'b0;
      if ({x3, y3, z3} !== 3'((k - 1) / 4) || busy3 !== 1'b1 || done3 !== 1'b0) bad = 1'b1;
    end
    chk("s3_step_xyz_busy", 32'(bad), 32'd0);
    tick();
    chk3("s3_done", 3'd0, 1'b0, 1'b1, 16'h5555, 8'h00, 1'b1);
    tick();
    chk("s3_done_pulse", 32'(done3), 32'd0);

    // Reset mid-run at t+10 clears all outputs on the next edge.
    start3 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      start3 = 1'b0;
    end
    chk("s3_mid_row", 32'({x3, y3, z3}), 32'd2);
    chk("s3_mid_result", 32'(result3), 32'h0005);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk3("s3_rst_mid", 3'd0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
